mct_rd_arbiter: RTL

- Shares one AXI4 read master port (AR + R channels) among C_NUM_PORTS read requesters, e.g. the NFA loader and the query reader, so both can have reads in flight at once instead of being time-multiplexed by state.
- Round-robin arbitration on the AR channel.
- In-order routing of R beats back to the issuing requester through a route FIFO. AXI reads without ID return in issue order.
- Sits between the per-stream mct_axi_read_master instances and the kernel's m_axi read port.

---
 rtl/mct_rd_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/mct_rd_arbiter.sv
// mct_rd_arbiter: shares one AXI4 read port among requesters (round-robin AR, in-order R routing).
// Define MCT_RD_ARB_STRICT_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module mct_rd_arbiter #(
  parameter int C_NUM_PORTS        = 2,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_MAX_OUTSTANDING  = 8
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [C_NUM_PORTS-1:0]                      s_arvalid,
  output logic [C_NUM_PORTS-1:0]                      s_arready,
  input  logic [C_NUM_PORTS*C_M_AXI_ADDR_WIDTH-1:0]   s_araddr,
  input  logic [C_NUM_PORTS*8-1:0]                    s_arlen,
  output logic [C_NUM_PORTS-1:0]                      s_rvalid,
  input  logic [C_NUM_PORTS-1:0]                      s_rready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]               s_rdata,
  output logic                                        s_rlast,
  output logic                                        m_axi_arvalid,
  input  logic                                        m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]               m_axi_araddr,
  output logic [7:0]                                  m_axi_arlen,
  input  logic                                        m_axi_rvalid,
  output logic                                        m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]               m_axi_rdata,
  input  logic                                        m_axi_rlast,
  output logic [$clog2(C_MAX_OUTSTANDING):0]          outstanding
);
  localparam int IW = $clog2(C_NUM_PORTS);
  localparam int PW = $clog2(C_MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam logic [0:0] ARB_IDLE = 1'b0;
  localparam logic [0:0] ARB_ADDR = 1'b1;

  logic [0:0]    r_state;
  logic [IW-1:0] r_grant_q;
  logic [IW-1:0] r_fifo [C_MAX_OUTSTANDING];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
`ifndef MCT_RD_ARB_STRICT_PRIO_EN
  logic [IW-1:0] r_rr_ptr;
`endif

  assign w_full  = r_count == CW'(C_MAX_OUTSTANDING);
  assign w_empty = r_count == '0;
  assign w_head  = r_fifo[r_rptr];
  assign w_push  = r_state == ARB_ADDR && m_axi_arready;
  assign w_pop   = m_axi_rvalid && m_axi_rready && m_axi_rlast;

  // Scan downward so the last hit is the closest to the start of the search.
  always_comb begin
    w_win = '0;
    for (int k = C_NUM_PORTS - 1; k >= 0; k--) begin
`ifdef MCT_RD_ARB_STRICT_PRIO_EN
      if (s_arvalid[k]) w_win = IW'(k);
`else
      if (s_arvalid[(int'(r_rr_ptr) + k) % C_NUM_PORTS]) w_win = IW'((int'(r_rr_ptr) + k) % C_NUM_PORTS);
`endif
    end
  end

  assign m_axi_arvalid = r_state == ARB_ADDR;
  assign m_axi_araddr  = s_araddr[int'(r_grant_q)*AW +: AW];
  assign m_axi_arlen   = s_arlen[int'(r_grant_q)*8 +: 8];
  assign s_arready     = w_push ? C_NUM_PORTS'(1) << r_grant_q : '0;
  assign s_rvalid      = (m_axi_rvalid && !w_empty) ? C_NUM_PORTS'(1) << w_head : '0;
  assign m_axi_rready  = s_rready[w_head] && !w_empty;
  assign s_rdata       = m_axi_rdata;
  assign s_rlast       = m_axi_rlast;
  assign outstanding   = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ARB_IDLE;
      r_grant_q <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
`ifndef MCT_RD_ARB_STRICT_PRIO_EN
      r_rr_ptr  <= '0;
`endif
    end else begin
      if (r_state == ARB_IDLE && |s_arvalid && !w_full) begin
        r_state   <= ARB_ADDR;
        r_grant_q <= w_win;
      end
      if (w_push) begin
        r_state <= ARB_IDLE;
        r_wptr  <= r_wptr + PW'(1);
`ifndef MCT_RD_ARB_STRICT_PRIO_EN
        r_rr_ptr <= (r_grant_q == IW'(C_NUM_PORTS - 1)) ? '0 : r_grant_q + IW'(1);
`endif
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= r_grant_q;
  end
endmodule
